// File: rtl/mem_bus_arb.sv
// Two-requester memory bus arbiter: the MEM stage wins over instruction fetch, and bus outputs are registered.
// Optional macro ARB_TIMEOUT_EN adds an 8-bit busy-cycle watchdog that drives bus_err.
module mem_bus_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stallreq,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic [2:0]  dbg_state
);

  // Handshake: a request is taken in IDLE; bus_req stays high with constant
  // payload until bus_ack is sampled, and drops on the following edge.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSY_MEM = 3'd1,
    BUSY_IF  = 3'd2,
    DONE_MEM = 3'd3,
    DONE_IF  = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        discard;
  logic [31:0] rdata_q;
  logic        timeout;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       bus_err_q;
  assign timeout = (tmo_cnt == 8'hFF) && !bus_ack;
  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign dbg_state    = state;
  assign if_stallreq  = if_req  && (state != DONE_IF);
  assign mem_stallreq = mem_req && (state != DONE_MEM);
  assign if_rdata     = (state == DONE_IF)  ? rdata_q : 32'h0;
  assign mem_rdata    = (state == DONE_MEM) ? rdata_q : 32'h0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_req)     state_next = BUSY_MEM;
        else if (if_req) state_next = BUSY_IF;
      end
      BUSY_MEM: if (bus_ack || timeout) state_next = (discard || flush) ? IDLE : DONE_MEM;
      BUSY_IF:  if (bus_ack || timeout) state_next = (discard || flush) ? IDLE : DONE_IF;
      DONE_MEM: if (flush || !stall[4]) state_next = IDLE;
      DONE_IF:  if (flush || !stall[1]) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      discard   <= 1'b0;
      rdata_q   <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt   <= 8'h0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
`ifdef ARB_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          discard <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt <= 8'h0;
`endif
          if (mem_req) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (if_req) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= 4'hF;
            bus_addr  <= if_addr;
            bus_wdata <= 32'h0;
          end
        end
        BUSY_MEM, BUSY_IF: begin
          if (flush) discard <= 1'b1;
          if (bus_ack || timeout) begin
            // Timeout completes like an ack but returns zero data.
            rdata_q   <= bus_ack ? bus_rdata : 32'h0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= 4'h0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
`ifdef ARB_TIMEOUT_EN
            bus_err_q <= !bus_ack;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb: each scenario drives the requesters and a hand-played bus slave,
// then checks outputs #1 after the edge against hand-computed values.
module tb_mem_bus_arb;

  localparam logic [2:0] S_IDLE = 3'd0, S_BUSY_MEM = 3'd1, S_BUSY_IF = 3'd2,
                         S_DONE_MEM = 3'd3, S_DONE_IF = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stallreq;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stallreq;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic [2:0]  dbg_state;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mem_bus_arb dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stallreq(if_stallreq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one edge, then leave time for registered outputs to settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: play the bus slave for one cycle with an ack and queue its data
  task automatic drive_ack(input logic [31:0] data);
    bus_ack   = 1'b1;
    bus_rdata = data;
    exp_q.push_back(data);
    step();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 6'h0; flush = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    bus_rdata = 32'h0; bus_ack = 1'b0;
    step(); step();

    // reset state
    check("rst_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
    check("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_sel", {28'h0, bus_sel}, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    step();

    // IF only, ack in first BUSY cycle
    if_req = 1'b1; if_addr = 32'h100; #1;
    check("if_stall_c0", {31'h0, if_stallreq}, 32'h1);
    step();
    check("if_grant_state", {29'h0, dbg_state}, {29'h0, S_BUSY_IF});
    check("if_bus_req", {31'h0, bus_req}, 32'h1);
    check("if_bus_addr", bus_addr, 32'h100);
    check("if_bus_ctl", {27'h0, bus_we, bus_sel}, 32'h0F);
    check("if_stall_c1", {31'h0, if_stallreq}, 32'h1);
    drive_ack(32'h3C010001);
    check("if_stall_c2", {31'h0, if_stallreq}, 32'h0);
    check("if_rdata", if_rdata, exp_q.pop_front());
    check("if_bus_req_drop", {31'h0, bus_req}, 32'h0);
    step();
    if_req = 1'b0; #1;
    check("if_back_idle", {29'h0, dbg_state}, {29'h0, S_IDLE});
    check("if_rdata_cleared", if_rdata, 32'h0);

    // simultaneous requests, MEM wins
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h2000;
    step();
    check("sim_bus_addr", bus_addr, 32'h2000);
    check("sim_state", {29'h0, dbg_state}, {29'h0, S_BUSY_MEM});
    check("sim_if_stall", {31'h0, if_stallreq}, 32'h1);
    drive_ack(32'h11111111);
    check("sim_mem_done", {29'h0, dbg_state}, {29'h0, S_DONE_MEM});
    check("sim_mem_rdata", mem_rdata, exp_q.pop_front());
    check("sim_mem_stall", {31'h0, mem_stallreq}, 32'h0);
    check("sim_if_wait", {31'h0, if_stallreq}, 32'h1);
    mem_req = 1'b0;
    step();
    check("sim_idle_gap", {29'h0, dbg_state}, {29'h0, S_IDLE});
    check("sim_idle_noreq", {31'h0, bus_req}, 32'h0);
    step();
    check("sim_if_grant", {29'h0, dbg_state}, {29'h0, S_BUSY_IF});
    check("sim_if_addr", bus_addr, 32'h104);
    drive_ack(32'h22222222);
    check("sim_if_rdata", if_rdata, exp_q.pop_front());
    step();
    if_req = 1'b0;

    // write hold with ack after 5 busy cycles
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF;
    step();
    mem_wdata = 32'h0; mem_sel = 4'h0; mem_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("wr_hold_ctl", {26'h0, bus_req, bus_we, bus_sel}, 32'h33);
      check("wr_hold_addr", bus_addr, 32'h40);
      check("wr_hold_wdata", bus_wdata, 32'hDEADBEEF);
      step();
    end
    check("wr_ack_cycle_wdata", bus_wdata, 32'hDEADBEEF);
    drive_ack(32'h0000A5A5);
    check("wr_req_drop", {31'h0, bus_req}, 32'h0);
    check("wr_done", {29'h0, dbg_state}, {29'h0, S_DONE_MEM});

    // stall hold in DONE_MEM
    stall = 6'b010000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_state", {29'h0, dbg_state}, {29'h0, S_DONE_MEM});
      check("stall_rdata", mem_rdata, 32'h0000A5A5);
      check("stall_mem_stall", {31'h0, mem_stallreq}, 32'h0);
    end
    void'(exp_q.pop_front());
    stall = 6'h0; mem_req = 1'b0; mem_we = 1'b0;
    step();
    check("stall_release", {29'h0, dbg_state}, {29'h0, S_IDLE});
    check("stall_rdata_zero", mem_rdata, 32'h0);

    // flush during BUSY_IF
    if_req = 1'b1; if_addr = 32'h300;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; #1;
    check("fl_still_busy", {29'h0, dbg_state}, {29'h0, S_BUSY_IF});
    check("fl_bus_req", {31'h0, bus_req}, 32'h1);
    drive_ack(32'h77777777);
    void'(exp_q.pop_front());
    if_req = 1'b0; #1;
    check("fl_skip_done", {29'h0, dbg_state}, {29'h0, S_IDLE});
    check("fl_if_rdata", if_rdata, 32'h0);
    check("fl_bus_req_drop", {31'h0, bus_req}, 32'h0);

    // flush in DONE_MEM overrides stall
    mem_req = 1'b1; mem_sel = 4'hF; mem_addr = 32'h80;
    step();
    drive_ack(32'h12345678);
    void'(exp_q.pop_front());
    stall = 6'b010000; flush = 1'b1; mem_req = 1'b0;
    step();
    flush = 1'b0; stall = 6'h0; #1;
    check("fl_done_idle", {29'h0, dbg_state}, {29'h0, S_IDLE});

    // reset mid-transaction, later ack ignored
    mem_req = 1'b1; mem_addr = 32'h500;
    step();
    check("rm_busy", {29'h0, dbg_state}, {29'h0, S_BUSY_MEM});
    rst = 1'b1;
    step();
    rst = 1'b0; mem_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF0000; #1;
    check("rm_idle", {29'h0, dbg_state}, {29'h0, S_IDLE});
    check("rm_bus_addr", bus_addr, 32'h0);
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0; #1;
    check("rm_ack_ignored", {29'h0, dbg_state}, {29'h0, S_IDLE});
    check("rm_mem_rdata", mem_rdata, 32'h0);

`ifdef ARB_TIMEOUT_EN
    // timeout: no ack, expect one bus_err pulse and zero data
    begin
      int err_pulses = 0;
      int done_seen  = 0;
      mem_req = 1'b1; mem_addr = 32'h600;
      step();
      for (int i = 0; i < 300 && done_seen == 0; i++) begin
        step();
        if (bus_err) err_pulses++;
        if (dbg_state == S_DONE_MEM) begin
          done_seen = 1;
          check("to_mem_rdata", mem_rdata, 32'h0);
          check("to_bus_req", {31'h0, bus_req}, 32'h0);
        end
      end
      check("to_reached_done", done_seen, 32'h1);
      mem_req = 1'b0;
      step();
      if (bus_err) err_pulses++;
      check("to_single_pulse", err_pulses, 32'h1);
      check("to_recovered", {29'h0, dbg_state}, {29'h0, S_IDLE});
    end
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
